fifo_burst_reader: RTL

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_reader_pkg.sv | 27 ++
 rtl/stream_skid_buffer.sv | 62 ++++++
 rtl/fifo_burst_reader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader_pkg
//  Description : Shared types and constants for the FIFO burst reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

   // Reader FSM states.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } reader_state_t;

   // Burst length used when the reader is instantiated with defaults.
   localparam int c_default_burst_len = 16;

   // Width of the completed-burst counter.
   localparam int c_burst_count_width = 32;

   // Width of the per-burst remaining-word counter: must hold 0..burst_len.
   function automatic int remaining_width(input int burst_len);
      return $clog2(burst_len + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_buffer
//  Description : Two-entry valid/ready buffer. Words come out in arrival
//                order one cycle after they are written, and the head word
//                holds steady while the sink stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buffer #(
   parameter int WIDTH = 33
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // Storage, pointers and occupancy; push and pop together keep the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Drains a show-ahead FIFO in bursts of BURST_LEN words, or
//                flushes a partial burst after TIMEOUT idle cycles, and
//                presents the words as a valid/ready stream with a last flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
   import fifo_reader_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LOG_DEPTH = 10,
   parameter int BURST_LEN = c_default_burst_len,
   parameter int TIMEOUT   = 256
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           fifo_empty,
   input  logic [WIDTH-1:0]               fifo_q,
   input  logic [LOG_DEPTH:0]             fifo_usedw,
   output logic                           fifo_rdreq,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic                           out_last,
   output logic                           busy,
   output logic [c_burst_count_width-1:0] burst_count
);

   localparam int c_rem_w   = remaining_width(BURST_LEN);
   localparam int c_usedw_w = LOG_DEPTH + 1;
   localparam int c_timer_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [c_usedw_w-1:0] c_burst_len_usedw = c_usedw_w'(BURST_LEN);
   localparam logic [c_rem_w-1:0]   c_burst_len_rem   = c_rem_w'(BURST_LEN);
   localparam logic [c_timer_w-1:0] c_timer_max       = c_timer_w'(TIMEOUT - 1);

   reader_state_t                  r_state;
   logic [c_rem_w-1:0]             r_remaining;
   logic [c_timer_w-1:0]           r_idle_timer;
   logic [c_burst_count_width-1:0] r_burst_count;

   logic             w_buf_in_ready;
   logic             w_buf_out_valid;
   logic [WIDTH:0]   w_buf_out_data;
   logic [1:0]       w_buf_count;
   logic             w_rdreq;
   logic             w_last_tag;
   logic             w_out_valid;

   // A pop needs an open burst, a word at the FIFO head and a free buffer slot.
   assign w_rdreq    = ~reset & (r_state == ST_BURST) & (r_remaining != '0) &
                       ~fifo_empty & w_buf_in_ready;
   assign w_last_tag = (r_remaining == c_rem_w'(1));

   assign fifo_rdreq  = w_rdreq;
   assign w_out_valid = ~reset & w_buf_out_valid;
   assign out_valid   = w_out_valid;
   assign out_data    = reset ? '0 : w_buf_out_data[WIDTH-1:0];
   assign out_last    = w_out_valid & w_buf_out_data[WIDTH];
   assign busy        = ~reset & ((r_state == ST_BURST) | (w_buf_count != 2'd0));
   assign burst_count = r_burst_count;

   stream_skid_buffer #(
      .WIDTH (WIDTH + 1)
   ) u_buf (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (w_rdreq),
      .in_ready  (w_buf_in_ready),
      .in_data   ({w_last_tag, fifo_q}),
      .out_valid (w_buf_out_valid),
      .out_ready (out_ready),
      .out_data  (w_buf_out_data),
      .count     (w_buf_count)
   );

   // Burst FSM: start on a full burst's worth of data or on idle timeout.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_remaining  <= '0;
         r_idle_timer <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (fifo_usedw >= c_burst_len_usedw) begin
                  r_state      <= ST_BURST;
                  r_remaining  <= c_burst_len_rem;
                  r_idle_timer <= '0;
               end else if (~fifo_empty && (fifo_usedw != '0) &&
                            (r_idle_timer == c_timer_max)) begin
                  r_state      <= ST_BURST;
                  r_remaining  <= c_rem_w'(fifo_usedw);
                  r_idle_timer <= '0;
               end else if (fifo_empty) begin
                  r_idle_timer <= '0;
               end else if (r_idle_timer != c_timer_max) begin
                  r_idle_timer <= r_idle_timer + c_timer_w'(1);
               end
            end
            ST_BURST: begin
               r_idle_timer <= '0;
               if (w_rdreq) begin
                  r_remaining <= r_remaining - c_rem_w'(1);
                  if (w_last_tag) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Count bursts as their last word leaves on the output stream.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_burst_count <= '0;
      end else if (w_out_valid && out_ready && w_buf_out_data[WIDTH]) begin
         r_burst_count <= r_burst_count + 1'b1;
      end
   end

endmodule
`default_nettype wire
